// File: rtl/fb_scan_reader.sv
// Framebuffer scan-out engine: tracks display position from the timing strobes,
// issues one read per active in-image pixel and returns a latency-aligned colour stream.
module fb_scan_reader #(
   parameter int unsigned        ADDR_W  = 18,
   parameter int unsigned        COLOR_W = 8,
   parameter int unsigned        H_SRC   = 256,
   parameter int unsigned        V_SRC   = 256,
   parameter int unsigned        RD_LAT  = 2,
   parameter logic [COLOR_W-1:0] BORDER  = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               vid_vs,
   input  logic               vid_de,
   input  logic [1:0]         scale_req,
   input  logic               bank_req,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_rd,
   input  logic [COLOR_W-1:0] mem_q,
   output logic [COLOR_W-1:0] pix_out,
   output logic               pix_de,
   output logic               bank_active,
   output logic [15:0]        frame_cnt
);

   localparam int unsigned POS_W  = 16;
   localparam int unsigned FCNT_W = 16;
   localparam int unsigned PIPE_D = RD_LAT + 1;
   localparam logic [ADDR_W-1:0] BANK_OFF  = ADDR_W'(H_SRC * V_SRC);
   localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_SRC);

   logic [POS_W-1:0]   x_q, x_d, y_q, y_d;
   logic [ADDR_W-1:0]  line_base_q, line_base_d;
   logic [1:0]         scale_q, scale_d;
   logic               bank_q, bank_d;
   logic               armed_q, armed_d;
   logic               de_prev_q, de_prev_d;
   logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic               mem_rd_q, mem_rd_d;
   logic [PIPE_D-1:0]  tag_de_q, tag_de_d, tag_img_q, tag_img_d;
   logic [COLOR_W-1:0] pix_out_q, pix_out_d;
   logic               pix_de_q, pix_de_d;

   logic [1:0]         scale_in, eff_scale;
   logic               eff_bank, eff_armed, in_img;
   logic [POS_W-1:0]   cur_x, cur_y, sx, sy, scale_mask, y_next;
   logic [ADDR_W-1:0]  cur_base, rd_addr;

   // A frame-start cycle already uses the new frame's settings at position (0,0).
   always_comb begin
      scale_in   = (scale_req == 2'd3) ? 2'd2 : scale_req;
      eff_scale  = vid_vs ? scale_in : scale_q;
      eff_bank   = vid_vs ? bank_req : bank_q;
      eff_armed  = vid_vs | armed_q;
      cur_x      = vid_vs ? '0 : x_q;
      cur_y      = vid_vs ? '0 : y_q;
      cur_base   = vid_vs ? '0 : line_base_q;
      sx         = cur_x >> eff_scale;
      sy         = cur_y >> eff_scale;
      in_img     = eff_armed & (32'(sx) < H_SRC) & (32'(sy) < V_SRC);
      rd_addr    = (eff_bank ? BANK_OFF : '0) + cur_base + ADDR_W'(sx);
      scale_mask = (POS_W'(1) << scale_q) - POS_W'(1);
      y_next     = y_q + POS_W'(1);
   end

   // Position, line base and frame bookkeeping; counters saturate so they never wrap into the image.
   always_comb begin
      x_d         = x_q;
      y_d         = y_q;
      line_base_d = line_base_q;
      scale_d     = scale_q;
      bank_d      = bank_q;
      armed_d     = armed_q;
      frame_cnt_d = frame_cnt_q;
      de_prev_d   = vid_de;
      if (vid_vs) begin
         x_d         = POS_W'(vid_de);
         y_d         = '0;
         line_base_d = '0;
         scale_d     = scale_in;
         bank_d      = bank_req;
         armed_d     = 1'b1;
         frame_cnt_d = frame_cnt_q + FCNT_W'(armed_q);
      end else if (vid_de) begin
         if (x_q != '1) x_d = x_q + POS_W'(1);
      end else if (de_prev_q) begin
         x_d = '0;
         if (y_q != '1) begin
            y_d = y_next;
            // A new source line starts once every 2^scale display lines.
            if ((y_next & scale_mask) == '0) line_base_d = line_base_q + LINE_STEP;
         end
      end
   end

   // Read issue and tag pipeline that realigns returning data with its enable.
   always_comb begin
      mem_rd_d   = vid_de & in_img;
      mem_addr_d = mem_rd_d ? rd_addr : mem_addr_q;
      tag_de_d   = {tag_de_q[PIPE_D-2:0], vid_de};
      tag_img_d  = {tag_img_q[PIPE_D-2:0], in_img};
      pix_de_d   = tag_de_q[PIPE_D-1];
      pix_out_d  = '0;
      if (tag_de_q[PIPE_D-1]) pix_out_d = tag_img_q[PIPE_D-1] ? mem_q : BORDER;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_q         <= '0;
         y_q         <= '0;
         line_base_q <= '0;
         scale_q     <= '0;
         bank_q      <= 1'b0;
         armed_q     <= 1'b0;
         de_prev_q   <= 1'b0;
         frame_cnt_q <= '0;
         mem_addr_q  <= '0;
         mem_rd_q    <= 1'b0;
         tag_de_q    <= '0;
         tag_img_q   <= '0;
         pix_out_q   <= '0;
         pix_de_q    <= 1'b0;
      end else begin
         x_q         <= x_d;
         y_q         <= y_d;
         line_base_q <= line_base_d;
         scale_q     <= scale_d;
         bank_q      <= bank_d;
         armed_q     <= armed_d;
         de_prev_q   <= de_prev_d;
         frame_cnt_q <= frame_cnt_d;
         mem_addr_q  <= mem_addr_d;
         mem_rd_q    <= mem_rd_d;
         tag_de_q    <= tag_de_d;
         tag_img_q   <= tag_img_d;
         pix_out_q   <= pix_out_d;
         pix_de_q    <= pix_de_d;
      end
   end

   assign mem_addr    = mem_addr_q;
   assign mem_rd      = mem_rd_q;
   assign pix_out     = pix_out_q;
   assign pix_de      = pix_de_q;
   assign bank_active = bank_q;
   assign frame_cnt   = frame_cnt_q;

endmodule
